// File: rtl/riscv_pkg.sv
// Shared encodings and enumerations for the multi-cycle RISC-V core.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_LS_D    = 3'b011;
    localparam logic [2:0] F3_LS_W    = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT} state_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;
    typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_ILLEGAL} kind_t;

endpackage

// File: rtl/riscv_regfile_p.sv
// Register file: two combinational read ports, one write port, x0 hardwired, debug tap.
module riscv_regfile_p #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic [XLEN-1:0] dbg_data,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    // Indices outside the implemented range read as zero instead of aliasing.
    assign rdata1   = (raddr1 != 5'd0 && 32'(raddr1) < NREGS) ? regs[raddr1[AW-1:0]] : '0;
    assign rdata2   = (raddr2 != 5'd0 && 32'(raddr2) < NREGS) ? regs[raddr2[AW-1:0]] : '0;
    assign dbg_data = (dbg_addr != 5'd0 && 32'(dbg_addr) < NREGS) ? regs[dbg_addr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0 && 32'(waddr) < NREGS) begin
            regs[waddr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV integer core: FETCH/DECODE/EXEC/MEM/WB with req/ready memories.
module riscv_multicycle_core import riscv_pkg::*; #(
    parameter int              XLEN     = 64,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DBG_REG  = 31
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            halted,
    output logic [63:0]     instret,
    output logic [XLEN-1:0] dbg_rd
);
    localparam logic [2:0] LS_F3 = (XLEN == 64) ? F3_LS_D : F3_LS_W;

    state_t state, next_state;
    logic [XLEN-1:0] pc, pc_next, pc_plus4, br_target;
    logic [31:0] ir;
    logic [XLEN-1:0] op_a, op_b, result, rs1_val, rs2_val;
    logic signed [31:0] imm32;
    logic signed [XLEN-1:0] imm;
    kind_t kind;
    alu_op_t alu_op;
    logic use_imm, uses_rd, uses_rs1, uses_rs2, illegal, br_taken, retire, rf_we;

    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    function automatic logic [XLEN-1:0] alu(input alu_op_t op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            default: return a + b;
        endcase
    endfunction

    riscv_regfile_p #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk(clk), .reset(reset),
        .raddr1(ir[19:15]), .raddr2(ir[24:20]), .dbg_addr(5'(DBG_REG)),
        .rdata1(rs1_val), .rdata2(rs2_val), .dbg_data(dbg_rd),
        .we(rf_we), .waddr(ir[11:7]), .wdata(result)
    );

    // Decode is a pure function of the latched instruction word.
    always_comb begin
        kind = K_ILLEGAL;
        alu_op = ALU_ADD;
        use_imm = 1'b0;
        uses_rd = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        imm32 = '0;
        case (ir[6:0])
            OP_RTYPE: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                if (ir[31:25] == F7_BASE && ir[14:12] == F3_ADD_SUB) begin
                    kind = K_ALU; alu_op = ALU_ADD;
                end else if (ir[31:25] == F7_SUB && ir[14:12] == F3_ADD_SUB) begin
                    kind = K_ALU; alu_op = ALU_SUB;
                end else if (ir[31:25] == F7_BASE && ir[14:12] == F3_AND) begin
                    kind = K_ALU; alu_op = ALU_AND;
                end else if (ir[31:25] == F7_BASE && ir[14:12] == F3_OR) begin
                    kind = K_ALU; alu_op = ALU_OR;
                end
            end
            OP_ADDI: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1; use_imm = 1'b1;
                imm32 = {{20{ir[31]}}, ir[31:20]};
                if (ir[14:12] == F3_ADD_SUB) kind = K_ALU;
            end
            OP_LOAD: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1;
                imm32 = {{20{ir[31]}}, ir[31:20]};
                if (ir[14:12] == LS_F3) kind = K_LOAD;
            end
            OP_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                if (ir[14:12] == LS_F3) kind = K_STORE;
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                if (ir[14:12] == F3_BEQ || ir[14:12] == F3_BNE) kind = K_BRANCH;
            end
            default: ;
        endcase
    end

    assign imm = XLEN'(imm32);
    assign illegal = (kind == K_ILLEGAL) || (uses_rd && !idx_ok(ir[11:7])) ||
                     (uses_rs1 && !idx_ok(ir[19:15])) || (uses_rs2 && !idx_ok(ir[24:20]));
    assign pc_plus4 = pc + XLEN'(4);
    assign br_target = pc + imm;
    assign br_taken = (op_a == op_b) ^ ir[12];

    always_ff @(posedge clk) begin
        if (reset) state <= ST_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we = 1'b0;
        rf_we = 1'b0;
        retire = 1'b0;
        pc_next = pc;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) next_state = ST_DECODE;
            end
            ST_DECODE: next_state = illegal ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                case (kind)
                    K_ALU:            next_state = ST_WB;
                    K_LOAD, K_STORE:  next_state = ST_MEM;
                    K_BRANCH: begin
                        if (br_taken && br_target[1:0] != 2'b00) begin
                            next_state = ST_HALT;
                        end else begin
                            pc_next = br_taken ? br_target : pc_plus4;
                            retire = 1'b1;
                            next_state = ST_FETCH;
                        end
                    end
                    default:          next_state = ST_HALT;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we = (kind == K_STORE);
                if (dmem_ready) begin
                    if (kind == K_STORE) begin
                        pc_next = pc_plus4;
                        retire = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        next_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we = 1'b1;
                pc_next = pc_plus4;
                retire = 1'b1;
                next_state = ST_FETCH;
            end
            default: next_state = ST_HALT;
        endcase
        // Reset aborts any access in flight within the same cycle.
        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we = 1'b0;
            rf_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            instret <= '0;
        end else begin
            pc <= pc_next;
            if (retire) instret <= instret + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_FETCH && imem_ready) ir <= imem_rdata;
        if (state == ST_DECODE) begin
            op_a <= rs1_val;
            op_b <= rs2_val;
        end
        if (state == ST_EXEC) result <= (kind == K_ALU) ? alu(alu_op, op_a, use_imm ? imm : op_b)
                                                        : op_a + imm;
        if (state == ST_MEM && dmem_ready && kind == K_LOAD) result <= dmem_rdata;
    end

    assign imem_addr = pc;
    assign dmem_addr = result;
    assign dmem_wdata = op_b;
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench: 64-bit core with wait-state memories plus a 32-bit/16-register core.
module tb_riscv_multicycle_core;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } dtx_t;

    logic clk;
    logic rst_a, rst_b;
    int checks = 0;
    int passed = 0;
    int dwait = 0;
    int dcnt = 0;
    bit dm_busy = 0;
    dtx_t dm_cur;
    logic [63:0] fq[$];
    dtx_t dq[$];
    logic [31:0] imem_a [0:63];
    logic [63:0] dmem_a [0:15];
    logic [31:0] imem_b [0:63];

    logic a_imem_req, a_imem_ready, a_dmem_req, a_dmem_we, a_dmem_ready, a_halted;
    logic [63:0] a_imem_addr, a_dmem_addr, a_dmem_wdata, a_dmem_rdata, a_instret, a_dbg_rd;
    logic [31:0] a_imem_rdata;

    logic b_imem_req, b_imem_ready, b_dmem_req, b_dmem_we, b_dmem_ready, b_halted;
    logic [31:0] b_imem_addr, b_dmem_addr, b_dmem_wdata, b_dmem_rdata, b_dbg_rd, b_imem_rdata;
    logic [63:0] b_instret;

    riscv_multicycle_core #(.XLEN(64), .NREGS(32), .RESET_PC(64'd0), .DBG_REG(31)) u_a (
        .clk(clk), .reset(rst_a),
        .imem_req(a_imem_req), .imem_addr(a_imem_addr), .imem_ready(a_imem_ready),
        .imem_rdata(a_imem_rdata),
        .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .dmem_addr(a_dmem_addr),
        .dmem_wdata(a_dmem_wdata), .dmem_ready(a_dmem_ready), .dmem_rdata(a_dmem_rdata),
        .halted(a_halted), .instret(a_instret), .dbg_rd(a_dbg_rd)
    );

    riscv_multicycle_core #(.XLEN(32), .NREGS(16), .RESET_PC(32'd0), .DBG_REG(1)) u_b (
        .clk(clk), .reset(rst_b),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ready(b_imem_ready),
        .imem_rdata(b_imem_rdata),
        .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr),
        .dmem_wdata(b_dmem_wdata), .dmem_ready(b_dmem_ready), .dmem_rdata(b_dmem_rdata),
        .halted(b_halted), .instret(b_instret), .dbg_rd(b_dbg_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: zero-wait instruction fetch, data side with programmable wait count.
    assign a_imem_ready = a_imem_req;
    assign a_imem_rdata = imem_a[a_imem_addr[7:2]];
    assign a_dmem_ready = a_dmem_req && (dcnt >= dwait);
    assign a_dmem_rdata = dmem_a[a_dmem_addr[6:3]];
    assign b_imem_ready = b_imem_req;
    assign b_imem_rdata = imem_b[b_imem_addr[7:2]];
    assign b_dmem_ready = b_dmem_req;
    assign b_dmem_rdata = '0;

    always @(posedge clk) begin
        if (rst_a || !a_dmem_req || a_dmem_ready) dcnt <= 0;
        else dcnt <= dcnt + 1;
        if (!rst_a && a_dmem_req && a_dmem_ready && a_dmem_we) dmem_a[a_dmem_addr[6:3]] <= a_dmem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Fetch scoreboard: every completed fetch must match the next expected PC.
    always @(negedge clk) begin
        #2;
        if (!rst_a && a_imem_req && a_imem_ready) begin
            if (fq.size() == 0) chk("fetch_unexpected", a_imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("fetch_addr", a_imem_addr, fq.pop_front());
        end
    end

    // Data scoreboard: request fields checked on every cycle of each access, including waits.
    always @(negedge clk) begin
        #2;
        if (rst_a) begin
            dm_busy = 0;
        end else if (a_dmem_req) begin
            if (!dm_busy) begin
                if (dq.size() == 0) begin
                    chk("dmem_unexpected", a_dmem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                    dm_cur = '0;
                end else begin
                    dm_cur = dq.pop_front();
                end
                dm_busy = 1;
            end
            chk("dmem_we", {63'd0, a_dmem_we}, {63'd0, dm_cur.we});
            chk("dmem_addr", a_dmem_addr, dm_cur.addr);
            if (dm_cur.we) chk("dmem_wdata", a_dmem_wdata, dm_cur.wdata);
            if (a_dmem_ready) dm_busy = 0;
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_ret(input bit sel, input logic [63:0] tgt, output int n);
        n = 0;
        while (((sel ? b_instret : a_instret) !== tgt) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release_a();
        @(negedge clk);
        rst_a = 1'b0;
        #1;
    endtask

    task automatic clear_a();
        for (int i = 0; i < 64; i++) imem_a[i] = 32'd0;
        for (int i = 0; i < 16; i++) dmem_a[i] = 64'd0;
    endtask

    initial begin
        int n;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // ALU sequence, then a store and a load each stretched by three wait cycles.
        clear_a();
        imem_a[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem_a[1] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011);
        imem_a[2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd31);
        imem_a[3] = enc_s(12'd8, 5'd31, 5'd0, 3'b011);
        imem_a[4] = enc_i(12'd8, 5'd0, 3'b011, 5'd5, 7'b0000011);
        imem_a[5] = enc_i(12'd7, 5'd5, 3'b000, 5'd31, 7'b0010011);
        for (int i = 0; i < 7; i++) fq.push_back(64'(i * 4));
        dq.push_back('{we: 1'b1, addr: 64'd8, wdata: 64'd2});
        dq.push_back('{we: 1'b0, addr: 64'd8, wdata: 64'd0});
        dwait = 3;
        cyc(3);
        chk("rst_imem_req", {63'd0, a_imem_req}, 64'd0);
        chk("rst_dmem_req", {63'd0, a_dmem_req}, 64'd0);
        chk("rst_instret", a_instret, 64'd0);
        chk("rst_halted", {63'd0, a_halted}, 64'd0);
        release_a();
        chk("first_imem_req", {63'd0, a_imem_req}, 64'd1);
        chk("first_imem_addr", a_imem_addr, 64'd0);
        wait_ret(1'b0, 64'd3, n);
        chk("alu3_cycles", 64'(n), 64'd12);
        chk("alu3_dbg", a_dbg_rd, 64'd2);
        cyc(6);
        chk("st_wait_instret", a_instret, 64'd3);
        chk("st_wait_req", {63'd0, a_dmem_req}, 64'd1);
        cyc(1);
        chk("st_done_instret", a_instret, 64'd4);
        wait_ret(1'b0, 64'd5, n);
        chk("ld_cycles", 64'(n), 64'd8);
        wait_ret(1'b0, 64'd6, n);
        chk("ld_use_cycles", 64'(n), 64'd4);
        chk("ld_use_dbg", a_dbg_rd, 64'd9);
        chk("st_mem_content", dmem_a[1], 64'd2);
        cyc(3);
        chk("illegal0_halted", {63'd0, a_halted}, 64'd1);
        chk("illegal0_req", {63'd0, a_imem_req}, 64'd0);
        chk("illegal0_instret", a_instret, 64'd6);
        chk("t1_fetch_left", 64'(fq.size()), 64'd0);
        chk("t1_dmem_left", 64'(dq.size()), 64'd0);

        // Branches: not-taken BNE, backward BEQ, forward BNE, misaligned target halts.
        rst_a = 1'b1;
        dwait = 0;
        clear_a();
        imem_a[0] = enc_b(13'd8, 5'd0, 5'd0, 3'b001);
        imem_a[1] = enc_i(12'd0, 5'd0, 3'b000, 5'd3, 7'b0010011);
        imem_a[2] = enc_b(13'd12, 5'd0, 5'd3, 3'b001);
        imem_a[3] = enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'b0010011);
        imem_a[4] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000);
        imem_a[5] = enc_i(12'd9, 5'd3, 3'b000, 5'd31, 7'b0010011);
        imem_a[6] = enc_b(13'd2, 5'd0, 5'd0, 3'b000);
        fq.push_back(64'h00); fq.push_back(64'h04); fq.push_back(64'h08);
        fq.push_back(64'h0C); fq.push_back(64'h10); fq.push_back(64'h08);
        fq.push_back(64'h14); fq.push_back(64'h18);
        cyc(2);
        release_a();
        wait_ret(1'b0, 64'd1, n);
        chk("bne_nt_cycles", 64'(n), 64'd3);
        wait_ret(1'b0, 64'd2, n);
        wait_ret(1'b0, 64'd3, n);
        chk("bne_nt2_cycles", 64'(n), 64'd3);
        wait_ret(1'b0, 64'd4, n);
        wait_ret(1'b0, 64'd5, n);
        chk("beq_back_cycles", 64'(n), 64'd3);
        wait_ret(1'b0, 64'd6, n);
        chk("bne_fwd_cycles", 64'(n), 64'd3);
        wait_ret(1'b0, 64'd7, n);
        chk("br_path_dbg", a_dbg_rd, 64'd10);
        cyc(4);
        chk("misalign_halted", {63'd0, a_halted}, 64'd1);
        chk("misalign_instret", a_instret, 64'd7);
        chk("t2_fetch_left", 64'(fq.size()), 64'd0);

        // Reset while a load waits in MEM: request drops at once, restart from the reset vector.
        rst_a = 1'b1;
        clear_a();
        imem_a[0] = enc_i(12'd8, 5'd0, 3'b011, 5'd31, 7'b0000011);
        dmem_a[1] = 64'h55;
        dwait = 3;
        fq.push_back(64'h00); fq.push_back(64'h00); fq.push_back(64'h04);
        dq.push_back('{we: 1'b0, addr: 64'd8, wdata: 64'd0});
        dq.push_back('{we: 1'b0, addr: 64'd8, wdata: 64'd0});
        cyc(2);
        release_a();
        cyc(4);
        chk("abort_pre_req", {63'd0, a_dmem_req}, 64'd1);
        rst_a = 1'b1;
        #1;
        chk("abort_req_drop", {63'd0, a_dmem_req}, 64'd0);
        dwait = 0;
        release_a();
        chk("abort_refetch_req", {63'd0, a_imem_req}, 64'd1);
        chk("abort_refetch_addr", a_imem_addr, 64'd0);
        chk("abort_instret", a_instret, 64'd0);
        chk("abort_rd_unchanged", a_dbg_rd, 64'd0);
        wait_ret(1'b0, 64'd1, n);
        chk("ld_zero_wait_cycles", 64'(n), 64'd5);
        chk("ld_zero_wait_dbg", a_dbg_rd, 64'h55);
        cyc(3);
        chk("t3_halted", {63'd0, a_halted}, 64'd1);
        chk("t3_fetch_left", 64'(fq.size()), 64'd0);
        chk("t3_dmem_left", 64'(dq.size()), 64'd0);

        // 32-bit, 16-register core: wraparound, x0 writes discarded, 64-bit load illegal.
        for (int i = 0; i < 64; i++) imem_b[i] = 32'd0;
        imem_b[0] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem_b[1] = enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd1);
        imem_b[2] = enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011);
        imem_b[3] = enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd1);
        imem_b[4] = enc_i(12'd0, 5'd0, 3'b011, 5'd2, 7'b0000011);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        wait_ret(1'b1, 64'd2, n);
        chk("x32_add_wrap", {32'd0, b_dbg_rd}, 64'hFFFF_FFFE);
        wait_ret(1'b1, 64'd4, n);
        chk("x0_reads_zero", {32'd0, b_dbg_rd}, 64'd0);
        cyc(3);
        chk("x32_ld_halted", {63'd0, b_halted}, 64'd1);
        chk("x32_ld_instret", b_instret, 64'd4);
        cyc(2);
        chk("x32_no_req", {63'd0, b_imem_req}, 64'd0);

        rst_b = 1'b1;
        imem_b[0] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd20);
        cyc(2);
        rst_b = 1'b0;
        #1;
        chk("nregs_pre_halted", {63'd0, b_halted}, 64'd0);
        cyc(4);
        chk("nregs_halted", {63'd0, b_halted}, 64'd1);
        chk("nregs_instret", b_instret, 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
